// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
//
// Sequential radix-2 Booth multiplier for signed 32-bit operands. It runs one
// Booth step per clock, so a multiply takes 32 iterations. The 64-bit signed
// product is held on the output until the next accepted start.
//
// Ports
//   clock         in   1   sole clock; all state updates on the rising edge
//   clr           in   1   synchronous active-high reset; beats start and RUN
//   start         in   1   request pulse; accepted in IDLE or DONE only
//   multiplicand  in  32   signed operand M, sampled at the accepting edge
//   multiplier    in  32   signed operand Q, sampled at the accepting edge
//   product       out 64   signed result M*Q, valid from the DONE cycle
//   ready         out  1   one-cycle completion pulse (high only in DONE)
//   busy          out  1   high exactly while iterating (RUN)
//   overflow      out  1   product does not fit a signed 32-bit value
//
// Handshake: start is a request that the block samples on a rising edge.
// The block ignores start while busy is high. ready is a single-cycle strobe
// with no back-pressure. A start seen in that same DONE cycle begins the next
// operation on that edge, so back-to-back multiplies need no idle gap.
// -----------------------------------------------------------------------------
module booth_mult_seq (
  input  logic        clock,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [63:0] product,
  output logic        ready,
  output logic        busy,
  output logic        overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;

  // P[64:33] = A (accumulator), P[32:1] = Q, P[0] = Q-1 (last bit shifted out)
  logic [64:0] p_reg;
  logic [31:0] m_reg;
  logic [5:0]  cnt;
  logic        ovf_reg;

  logic [32:0] a_ext;
  logic [32:0] m_ext;
  logic [32:0] sum;
  logic [64:0] p_shift;
  logic        accept;
  logic        last_iter;
  logic        ovf_next;

  // One Booth step. The add/subtract is done 33 bits wide. This keeps
  // A - M exact when M = 0x80000000, because its negation needs 33 bits.
  // The sign of the wide sum then feeds the arithmetic right shift.
  always_comb begin
    a_ext = {p_reg[64], p_reg[64:33]};
    m_ext = {m_reg[31], m_reg};
    sum   = a_ext;
    case (p_reg[1:0])
      2'b01:   sum = a_ext + m_ext;
      2'b10:   sum = a_ext - m_ext;
      default: sum = a_ext;
    endcase
    p_shift = {sum[32], sum[31:0], p_reg[32:1]};
  end

  // The result overflows a signed 32-bit value when the upper word
  // (new P[64:33]) is not a pure sign extension of bit 31 (new P[32]).
  assign ovf_next  = (p_shift[64:33] != {32{p_shift[32]}});

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == 6'd31);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last_iter ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state   <= IDLE;
      p_reg   <= 65'd0;
      m_reg   <= 32'd0;
      cnt     <= 6'd0;
      ovf_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        m_reg <= multiplicand;
        p_reg <= {32'd0, multiplier, 1'b0};
        cnt   <= 6'd0;
      end else if (state == RUN) begin
        p_reg <= p_shift;
        cnt   <= cnt + 6'd1;
        // Overflow is captured only on the step that enters DONE. It then
        // stays with the product until a later operation completes.
        if (last_iter) begin
          ovf_reg <= ovf_next;
        end
      end
    end
  end

  assign product  = p_reg[64:1];
  assign ready    = (state == DONE);
  assign busy     = (state == RUN);
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
//
// Directed bench for booth_mult_seq. Each driver call that issues a start
// pushes the expected product, overflow flag and ready cycle into queues.
// A monitor process pops one entry per ready pulse and compares the DUT
// outputs against it. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  logic        clock = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [31:0] multiplicand = 32'd0;
  logic [31:0] multiplier = 32'd0;
  logic [63:0] product;
  logic        ready;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // exp_q holds {overflow, product}; exp_cyc_q holds the expected ready cycle.
  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];

  int busy_run = 0;
  int last_busy_run = 0;

  booth_mult_seq dut (
    .clock        (clock),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready),
    .busy         (busy),
    .overflow     (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // cyc = number of rising edges seen so far.
  always @(posedge clock) cyc++;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge. Start is sampled on the next rising edge.
  // The expected entry is pushed at the falling edge that follows.
  task automatic issue(input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp_p, input logic exp_ov);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(negedge clock);
    exp_q.push_back({exp_ov, exp_p});
    exp_cyc_q.push_back(cyc + 32);
    start = 1'b0;
  endtask

  // Returns at the falling edge where ready is high. The wait is bounded.
  task automatic wait_ready(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] m,
                        input logic [31:0] q, input logic [63:0] exp_p,
                        input logic exp_ov);
    issue(m, q, exp_p, exp_ov);
    wait_ready(name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (busy) begin
      busy_run++;
    end else begin
      if (busy_run > 0) last_busy_run = busy_run;
      busy_run = 0;
    end
    if (ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        logic [64:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("product", product, e[63:0]);
        check("overflow", {63'd0, overflow}, {63'd0, e[64]});
        check("ready_cycle", 64'(cyc), 64'(ec));
        check("busy_cycles", 64'(last_busy_run), 64'd32);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clock);
    check("rst_product", product, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    clr = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_product", product, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // 3 * 5. Afterwards the result must hold through IDLE.
    run_op("m3q5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    repeat (3) @(negedge clock);
    check("hold_product", product, 64'h0000_0000_0000_000F);
    check("hold_overflow", {63'd0, overflow}, 64'd0);
    check("hold_ready", {63'd0, ready}, 64'd0);

    run_op("m-7q6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    run_op("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    run_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
    run_op("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1);
    run_op("m1_max", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b0);
    run_op("zero", 32'd0, 32'd12345, 64'd0, 1'b0);

    // A start during RUN (iteration 10) with other operands is ignored.
    // The operands also stay changed for the rest of the run.
    issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    repeat (9) @(negedge clock);
    start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
    @(negedge clock);
    start = 1'b0;
    wait_ready("ignore_start");

    // clr at iteration 10 discards the operation.
    issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    repeat (9) @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    check("clr_busy", {63'd0, busy}, 64'd0);
    check("clr_product", product, 64'd0);
    check("clr_ready", {63'd0, ready}, 64'd0);
    check("clr_overflow", {63'd0, overflow}, 64'd0);
    repeat (30) @(negedge clock);
    check("clr_no_result", product, 64'd0);
    run_op("m2q2", 32'd2, 32'd2, 64'd4, 1'b0);

    // Back-to-back: a start held during DONE launches -1 * -1.
    run_op("m2q3", 32'd2, 32'd3, 64'd6, 1'b0);
    run_op("b2b_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: clr  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: start  in  1  request pulse; sampled on rising edge.
REQ-004 SHALL have ports: multiplicand  in  32  signed two's-complement operand M.
REQ-005 SHALL have ports: multiplier  in  32  signed two's-complement operand Q.
REQ-006 SHALL have ports: product  out  64  signed result M*Q.
REQ-007 SHALL have ports: ready  out  1  one-cycle completion pulse.
REQ-008 SHALL have ports: busy  out  1  high while iterating.
REQ-009 SHALL have ports: overflow  out  1  result not representable as signed 32-bit.

Function
REQ-010 SHALL hold a 65-bit product register P: P[64:33]=A (accumulator), P[32:1]=Q, P[0]=Q-1 (last bit shifted out), plus a 32-bit latched M and a 6-bit iteration counter.
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL, in IDLE or DONE with start=1, latch M<=multiplicand, load P<={32'b0, multiplier, 1'b0}, clear counter, go to RUN.
REQ-013 SHALL, in IDLE with start=0, stay IDLE with P, product and overflow unchanged.
REQ-014 SHALL, each RUN cycle, select on P[1:0]: 01 -> A+M; 10 -> A-M; 00/11 -> A unchanged.
REQ-015 SHALL compute the add/subtract as a 33-bit sign-extended sum S; P then loads {S[32], S[31:0], P[32:1]} (arithmetic right shift by one), so M = 0x80000000 is exact.
REQ-016 SHALL increment the counter once per RUN cycle; after the 32nd iteration it SHALL go to DONE.
REQ-017 SHALL drive product = P[64:1] continuously; the value is valid from the DONE cycle and held until the next accepted start.
REQ-018 SHALL drive ready=1 only in DONE; it is exactly one cycle wide; DONE with start=0 goes to IDLE.
REQ-019 SHALL give latency: start sampled at edge k -> 32 RUN edges (k+1..k+32) -> ready high in the cycle following edge k+32.
REQ-020 SHALL drive busy=1 exactly in RUN.
REQ-021 SHALL ignore start while in RUN: no reload, and the counter and P are unaffected.
REQ-022 SHALL accept start asserted during DONE (back-to-back); ready still pulses that cycle and the next operation starts at that edge.
REQ-023 SHALL compute overflow = 1 iff product[63:32] is not all equal to product[31]; it is registered on entering DONE and held with product.
REQ-024 SHALL treat the operands as sampled only at the accepting edge; input changes during RUN have no effect.

Reset
REQ-025 SHALL, with clr=1 at a rising edge, set state=IDLE, P=0, M=0, counter=0, overflow=0; outputs product=0, ready=0, busy=0.
REQ-026 SHALL give clr priority over start and over RUN progress; an in-flight operation is discarded and no ready pulse is produced for it.
REQ-027 SHALL hold all outputs at their reset values until the first start accepted after clr deasserts.

Verification
REQ-028 Bench SHALL cover: start with M=3, Q=5 -> ready exactly 32 cycles after the start edge; product=0x000000000000000F; overflow=0; busy high for those 32 cycles.
REQ-029 Bench SHALL cover: M=-7, Q=6 -> product=0xFFFFFFFFFFFFFFD6; overflow=0.
REQ-030 Bench SHALL cover: M=0x80000000, Q=0x80000000 -> product=0x4000000000000000; overflow=1. Also M=0x80000000, Q=0xFFFFFFFF -> product=0x0000000080000000; overflow=1.
REQ-031 Bench SHALL cover: start at iteration 10 of an ongoing 3*5 with operands 9,9 -> ignored; result still 15; ready timing unchanged.
REQ-032 Bench SHALL cover: clr pulsed at iteration 10 -> next cycle busy=0, product=0, no ready; a subsequent start 2*2 -> product=4 after 32 cycles.
REQ-033 Bench SHALL cover: start held high in the DONE cycle with M=-1, Q=-1 -> first result valid; second op completes 32 cycles later with product=1 and overflow=0.
